dmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves the CPU's load/store port with a valid/ready request channel and a pulsed response. It replaces the zero-wait data memory so the core can be run against realistic memory latency. It holds a word-addressed storage array, latches one request at a time, waits a programmable number of cycles, commits or reads, and returns one response. Misaligned and out-of-range accesses get an error response.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request channel and pulsed response between CPU and data memory
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport slave (
        input  req_valid_i, req_write_i, addr_i, wdata_i, be_i,
        output req_ready_o, rsp_valid_o, rdata_o, err_o
    );

    modport master (
        output req_valid_i, req_write_i, addr_i, wdata_i, be_i,
        input  req_ready_o, rsp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory that answers one request after a programmable wait
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept, commit, acc_write, acc_err;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] idx;

    // The commit uses the live inputs on a zero-latency accept, otherwise the latched copy.
    always_comb begin
        accept    = state_q == IDLE && bus.req_valid_i;
        commit    = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd0);
        acc_write = state_q == IDLE ? bus.req_write_i : write_q;
        acc_addr  = state_q == IDLE ? bus.addr_i : addr_q;
        acc_wdata = state_q == IDLE ? bus.wdata_i : wdata_q;
        acc_be    = state_q == IDLE ? bus.be_i : be_q;
        acc_err   = acc_addr[1:0] != 2'b00 || {2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS);
        idx       = acc_addr[AW+1:2];
    end

    // Next-state, request latch and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                write_d = bus.req_write_i;
                addr_d  = bus.addr_i;
                wdata_d = bus.wdata_i;
                be_d    = bus.be_i;
                state_d = LATENCY == 0 ? RESP : WAIT;
                cnt_d   = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
            end
            WAIT: begin
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rdata_d = (acc_err || acc_write) ? 32'd0 : mem[idx];
            err_d   = acc_err;
        end
    end

    // Control and output registers; a reset drops any pending request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a legal store writes only its enabled bytes.
    always_ff @(posedge clk_i) begin
        if (commit && acc_write && !acc_err)
            for (int k = 0; k < 4; k++)
                if (acc_be[k]) mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
    end

    assign bus.req_ready_o = state_q == IDLE;
    assign bus.rsp_valid_o = state_q == RESP;
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test of a LATENCY=2 and a LATENCY=0 responder against a timing/memory model
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v [2] = '{1'b0, 1'b0};
    logic        w [2] = '{1'b0, 1'b0};
    logic [31:0] a [2] = '{32'd0, 32'd0};
    logic [31:0] wd [2] = '{32'd0, 32'd0};
    logic [3:0]  b [2] = '{4'd0, 4'd0};
    logic        rdy [2], rsp [2], er [2];
    logic [31:0] rd [2];

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    assign bus0.req_valid_i = v[0];
    assign bus0.req_write_i = w[0];
    assign bus0.addr_i      = a[0];
    assign bus0.wdata_i     = wd[0];
    assign bus0.be_i        = b[0];
    assign bus1.req_valid_i = v[1];
    assign bus1.req_write_i = w[1];
    assign bus1.addr_i      = a[1];
    assign bus1.wdata_i     = wd[1];
    assign bus1.be_i        = b[1];
    assign rdy[0] = bus0.req_ready_o;
    assign rsp[0] = bus0.rsp_valid_o;
    assign rd[0]  = bus0.rdata_o;
    assign er[0]  = bus0.err_o;
    assign rdy[1] = bus1.req_ready_o;
    assign rsp[1] = bus1.rsp_valid_o;
    assign rd[1]  = bus1.rdata_o;
    assign er[1]  = bus1.err_o;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(bus0));
    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1));

    int pass_n = 0;
    int tot_n  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    function automatic int lat_of(input int d);
        return d == 0 ? 2 : 0;
    endfunction

    // Model: age is the cycle index since acceptance (-1 when idle); the response cycle is age==latency.
    int          age [2] = '{-1, -1};
    logic        p_w [2];
    logic [31:0] p_a [2], p_wd [2];
    logic [3:0]  p_be [2];
    logic [31:0] e_rd [2] = '{32'd0, 32'd0};
    logic        e_er [2] = '{1'b0, 1'b0};
    bit          kn [2] = '{1'b1, 1'b1};
    logic [31:0] mm [2][128];
    bit          wr [2][128];

    task automatic commit_model(input int d);
        bit bad;
        int ix;
        bad = p_a[d][1:0] != 2'b00 || p_a[d][31:2] >= 30'd128;
        ix  = int'(p_a[d][8:2]);
        if (!bad && p_w[d]) begin
            for (int k = 0; k < 4; k++)
                if (p_be[d][k]) mm[d][ix][8*k +: 8] = p_wd[d][8*k +: 8];
            if (p_be[d] == 4'hF) wr[d][ix] = 1'b1;
        end
        e_er[d] = bad;
        e_rd[d] = (bad || p_w[d]) ? 32'd0 : mm[d][ix];
        kn[d]   = bad || p_w[d] || wr[d][ix];
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                age[d] = -1; e_rd[d] = 32'd0; e_er[d] = 1'b0; kn[d] = 1'b1;
            end else if (age[d] < 0) begin
                if (v[d]) begin
                    p_w[d] = w[d]; p_a[d] = a[d]; p_wd[d] = wd[d]; p_be[d] = b[d];
                    age[d] = 0;
                    if (lat_of(d) == 0) commit_model(d);
                end
            end else begin
                age[d]++;
                if (age[d] == lat_of(d)) commit_model(d);
                else if (age[d] > lat_of(d)) age[d] = -1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk(d == 0 ? "ready0" : "ready1", rdy[d], age[d] < 0);
            chk(d == 0 ? "rsp0" : "rsp1", rsp[d], age[d] == lat_of(d));
            if (kn[d]) chk(d == 0 ? "rdata0" : "rdata1", rd[d], e_rd[d]);
            if (age[d] == lat_of(d)) chk(d == 0 ? "err0" : "err1", er[d], e_er[d]);
        end
    end

    task automatic req(input int d, input logic wr_, input logic [31:0] ad, input logic [31:0] dt,
                       input logic [3:0] be_, output logic [31:0] r, output logic e, output int lat);
        int n = 0;
        v[d] = 1'b1; w[d] = wr_; a[d] = ad; wd[d] = dt; b[d] = be_;
        @(negedge clk);
        while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
        chk("accept", rdy[d], 1'b1);
        @(posedge clk);
        #1 v[d] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp[d] && lat < 20) begin @(negedge clk); lat++; end
        r = rd[d];
        e = er[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, last;
        logic        e, cur_w;
        logic [31:0] cur_d;
        int          lat, n;
        time         t, tp;
        last = 32'd0; tp = 0;
        repeat (3) @(negedge clk);
        chk("reset_ready", rdy[0], 1'b1);
        chk("reset_rsp", rsp[0], 1'b0);
        chk("reset_rdata", rd[0], 32'd0);
        chk("reset_err", er[0], 1'b0);
        #2 rst_n = 1'b1;

        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, lat);
        chk("st_lat", lat, 2);
        chk("st_err", e, 1'b0);
        chk("st_rdata", r, 32'd0);
        req(0, 1'b0, 32'h10, 32'd0, 4'h0, r, e, lat);
        chk("ld_lat", lat, 2);
        chk("ld_rdata", r, 32'hDEADBEEF);

        req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, r, e, lat);
        req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, r, e, lat);
        req(0, 1'b0, 32'h20, 32'd0, 4'h0, r, e, lat);
        chk("merge_rdata", r, 32'h11BB33DD);

        req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r, e, lat);
        req(0, 1'b0, 32'h22, 32'd0, 4'h0, r, e, lat);
        chk("misalign_err", e, 1'b1);
        chk("misalign_rdata", r, 32'd0);
        req(0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, r, e, lat);
        chk("range_err", e, 1'b1);
        req(0, 1'b0, 32'h0, 32'd0, 4'h0, r, e, lat);
        chk("word0_err", e, 1'b0);
        chk("word0_rdata", r, 32'hCAFEF00D);

        req(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, r, e, lat);
        req(0, 1'b0, 32'h30, 32'd0, 4'h0, r, e, lat);
        chk("pre_rdata", r, 32'h0BADF00D);
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h30; wd[0] = 32'h12345678; b[0] = 4'hF;
        n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 v[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", rdy[0], 1'b1);
        chk("async_rsp", rsp[0], 1'b0);
        chk("async_rdata", rd[0], 32'd0);
        chk("async_err", er[0], 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        req(0, 1'b0, 32'h30, 32'd0, 4'h0, r, e, lat);
        chk("dropped_store", r, 32'h0BADF00D);

        req(0, 1'b1, 32'h50, 32'h55AA55AA, 4'hF, r, e, lat);
        #1 rst_n = 1'b0;
        #1 chk("resp_reset_rsp", rsp[0], 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req(0, 1'b0, 32'h50, 32'd0, 4'h0, r, e, lat);
        chk("resp_reset_kept", r, 32'h55AA55AA);

        v[1] = 1'b1; w[1] = 1'b1; a[1] = 32'h40; wd[1] = 32'hA5000000; b[1] = 4'hF;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            @(negedge clk);
            while (!rdy[1] && n < 10) begin @(negedge clk); n++; end
            @(posedge clk);
            t = $time;
            if (i > 0) chk("accept_spacing", 32'(t - tp), 32'd20);
            tp = t;
            #1;
            cur_w = w[1];
            cur_d = wd[1];
            if (i == 7) v[1] = 1'b0;
            else if (w[1]) w[1] = 1'b0;
            else begin w[1] = 1'b1; wd[1] = 32'hA5000000 + 32'(i + 1); end
            @(negedge clk);
            chk("b2b_rsp", rsp[1], 1'b1);
            if (!cur_w) chk("b2b_load", rd[1], last);
            else last = cur_d;
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
